// File: rtl/encode_seq_if.sv
// Token input and LZS beat output bundle between the match finder, the
// sequencer and the encode_out bit packer.
interface encode_seq_if;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_end;
    logic        tok_type;
    logic [7:0]  tok_lit;
    logic [10:0] tok_off;
    logic [10:0] tok_len;
    logic        cnt_output_enable;
    logic [12:0] cnt_output;
    logic [3:0]  cnt_len;
    logic        cnt_finish;

    // Token source that also observes the beat stream.
    modport master (
        output tok_valid, tok_end, tok_type, tok_lit, tok_off, tok_len,
        input  tok_ready, cnt_output_enable, cnt_output, cnt_len, cnt_finish
    );

    // The sequencer itself.
    modport slave (
        input  tok_valid, tok_end, tok_type, tok_lit, tok_off, tok_len,
        output tok_ready, cnt_output_enable, cnt_output, cnt_len, cnt_finish
    );
endinterface

// File: rtl/encode_seq.sv
// LZS token-to-bitcode sequencer: turns literal/match/end tokens into
// variable-length code beats, appends the end marker, pads to PAD_W bits
// and then holds cnt_finish until reset.
module encode_seq #(
    parameter int PAD_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    encode_seq_if.slave  bus
);
    localparam int BP_W = $clog2(PAD_W);

    typedef enum logic [2:0] {
        S_IDLE, S_HEAD, S_LEN, S_EXT, S_ENDM, S_PAD, S_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic            r_type;
    logic [7:0]      r_lit;
    logic [10:0]     r_off, r_len, r_rem;
    logic [BP_W-1:0] r_bitpos;

    logic            r_oe, r_finish;
    logic [12:0]     r_out;
    logic [3:0]      r_cnt_len;

    logic            w_beat_en, w_final, w_accept;
    logic [12:0]     w_beat_data;
    logic [3:0]      w_beat_len;
    logic [10:0]     w_rem_next;
    logic [10:0]     w_r;
    logic [BP_W:0]   w_need;
    logic [BP_W-1:0] w_bitpos_next;

    // Length residue above the 8-symbol base, and bits left to the pad boundary.
    assign w_r           = r_len - 11'd8;
    assign w_need        = (BP_W+1)'(PAD_W) - {1'b0, r_bitpos};
    assign w_bitpos_next = r_bitpos + BP_W'(w_beat_len);

    // A new token is taken while idle or on the last beat of the current one,
    // so back-to-back tokens never see an idle bubble.
    assign bus.tok_ready = (r_state == S_IDLE) || w_final;
    assign w_accept      = bus.tok_valid && bus.tok_ready;

    // Decode the beat for the current state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        w_beat_en   = 1'b0;
        w_beat_data = 13'd0;
        w_beat_len  = 4'd0;
        w_final     = 1'b0;
        w_rem_next  = r_rem;
        unique case (r_state)
            S_HEAD: begin
                w_beat_en = 1'b1;
                if (!r_type) begin
                    w_beat_data = {5'd0, r_lit};
                    w_beat_len  = 4'd9;
                    w_final     = 1'b1;
                end else if (r_off < 11'd128) begin
                    w_beat_data = {4'd0, 2'b11, r_off[6:0]};
                    w_beat_len  = 4'd9;
                end else begin
                    w_beat_data = {2'b10, r_off};
                    w_beat_len  = 4'd13;
                end
            end
            S_LEN: begin
                w_beat_en = 1'b1;
                if (r_len < 11'd5) begin
                    w_beat_data = {11'd0, r_len[1:0] - 2'd2};
                    w_beat_len  = 4'd2;
                    w_final     = 1'b1;
                end else if (r_len < 11'd8) begin
                    w_beat_data = {9'd0, 2'b11, r_len[1:0] - 2'd1};
                    w_beat_len  = 4'd4;
                    w_final     = 1'b1;
                end else if (w_r < 11'd15) begin
                    w_beat_data = {5'd0, 4'hF, w_r[3:0]};
                    w_beat_len  = 4'd8;
                    w_final     = 1'b1;
                end else begin
                    w_beat_data = 13'h000F;
                    w_beat_len  = 4'd4;
                    w_rem_next  = w_r;
                end
            end
            S_EXT: begin
                w_beat_en  = 1'b1;
                w_beat_len = 4'd4;
                if (r_rem >= 11'd15) begin
                    w_beat_data = 13'h000F;
                    w_rem_next  = r_rem - 11'd15;
                end else begin
                    w_beat_data = {9'd0, r_rem[3:0]};
                    w_final     = 1'b1;
                end
            end
            S_ENDM: begin
                w_beat_en   = 1'b1;
                w_beat_data = 13'h0180;
                w_beat_len  = 4'd9;
            end
            S_PAD: begin
                w_beat_en  = 1'b1;
                w_beat_len = (w_need > (BP_W+1)'(15)) ? 4'd15 : w_need[3:0];
            end
            default: ;
        endcase
    end

    // Next-state selection; a final beat hands over directly to the next token.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:         if (w_accept) w_state_next = bus.tok_end ? S_ENDM : S_HEAD;
            S_HEAD:         if (r_type) w_state_next = S_LEN;
            S_LEN:          if (!w_final) w_state_next = S_EXT;
            S_EXT:          w_state_next = S_EXT;
            S_ENDM, S_PAD:  w_state_next = (w_bitpos_next == '0) ? S_DONE : S_PAD;
            default:        w_state_next = S_DONE;
        endcase
        if (w_final)
            w_state_next = w_accept ? (bus.tok_end ? S_ENDM : S_HEAD) : S_IDLE;
    end

    // State, token capture, extension remainder and stream bit position.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the reset is asynchronous, so it sits in the sensitivity list
        // and clears every register without waiting for a clock edge.
        if (rst) begin
            r_state  <= S_IDLE;
            r_type   <= 1'b0;
            r_lit    <= 8'd0;
            r_off    <= 11'd0;
            r_len    <= 11'd0;
            r_rem    <= 11'd0;
            r_bitpos <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            if (w_beat_en)
                r_bitpos <= w_bitpos_next;
            if (w_accept) begin
                r_type <= bus.tok_type;
                r_lit  <= bus.tok_lit;
                r_off  <= bus.tok_off;
                r_len  <= bus.tok_len;
            end
        end
    end

    // Registered beat outputs; data and length hold between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe      <= 1'b0;
            r_out     <= 13'd0;
            r_cnt_len <= 4'd0;
            r_finish  <= 1'b0;
        end else begin
            r_oe     <= w_beat_en;
            r_finish <= (r_state == S_DONE);
            if (w_beat_en) begin
                r_out     <= w_beat_data;
                r_cnt_len <= w_beat_len;
            end
        end
    end

    assign bus.cnt_output_enable = r_oe;
    assign bus.cnt_output        = r_out;
    assign bus.cnt_len           = r_cnt_len;
    assign bus.cnt_finish        = r_finish;
endmodule

// File: tb/tb_encode_seq.sv
// Scoreboard bench for encode_seq: the driver pushes the beats each token
// should produce into a queue, a monitor pops and compares them as the DUT
// presents beats.
module tb_encode_seq;
    localparam int PAD_W = 64;
    localparam int T     = 10;

    typedef struct {
        int data;
        int len;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #(T/2) clk = ~clk;

    encode_seq_if bus ();

    encode_seq #(.PAD_W(PAD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t exp_q[$];
    beat_t mon_b;
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    model_bits = 0;
    int    last_beat_cyc = 0;
    int    oe_run = 0;
    int    oe_run_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: beats from the LZS coding rules.
    task automatic push(input int data, input int len);
        beat_t b;
        b.data = data;
        b.len  = len;
        exp_q.push_back(b);
        model_bits += len;
    endtask

    task automatic model(input bit e, input bit t, input int lit, input int off, input int len);
        int r, need, n;
        if (e) begin
            push(32'h180, 9);
            need = (model_bits % PAD_W == 0) ? 0 : PAD_W - (model_bits % PAD_W);
            while (need > 0) begin
                n = (need > 15) ? 15 : need;
                push(0, n);
                need -= n;
            end
        end else if (!t) begin
            push(lit, 9);
        end else begin
            if (off < 128) push(32'h180 + off, 9);
            else           push(32'h1000 + off, 13);
            if (len <= 4)      push(len - 2, 2);
            else if (len <= 7) push(12 + len - 5, 4);
            else begin
                r = len - 8;
                if (r < 15) push(32'hF0 + r, 8);
                else begin
                    push(15, 4);
                    while (r >= 15) begin
                        push(15, 4);
                        r -= 15;
                    end
                    push(r, 4);
                end
            end
        end
    endtask

    // Monitor: compare each presented beat against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            oe_run = 0;
        end else begin
            if (bus.cnt_output_enable) begin
                oe_run++;
                if (oe_run > oe_run_max) oe_run_max = oe_run;
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", int'(bus.cnt_output), mon_b.data);
                    check("beat_len", int'(bus.cnt_len), mon_b.len);
                end
                last_beat_cyc = cyc;
            end else begin
                oe_run = 0;
            end
            if (bus.cnt_finish && exp_q.size() != 0)
                check("finish_with_pending", exp_q.size(), 0);
        end
    end

    // Present one token from a negedge; returns at the negedge after acceptance.
    task automatic send(input bit e, input bit t, input int lit, input int off,
                        input int len, output int acc_cyc);
        int k = 0;
        bus.tok_end   = e;
        bus.tok_type  = t;
        bus.tok_lit   = lit[7:0];
        bus.tok_off   = off[10:0];
        bus.tok_len   = len[10:0];
        bus.tok_valid = 1'b1;
        while (!bus.tok_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.tok_ready) begin
            check("accept_timeout", 0, 1);
            bus.tok_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        model(e, t, lit, off, len);
        acc_cyc = cyc;
        @(negedge clk);
        bus.tok_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_bits = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_finish(input string tag);
        int k = 0;
        while (!bus.cnt_finish && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finish_seen"}, int'(bus.cnt_finish), 1);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        check({tag, "_finish_latency"}, cyc - last_beat_cyc, 1);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_finish_held"}, int'(bus.cnt_finish), 1);
            check({tag, "_ready_low"}, int'(bus.tok_ready), 0);
            check({tag, "_no_beat"}, int'(bus.cnt_output_enable), 0);
        end
    endtask

    // Watchdog.
    initial begin
        #(T * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, b, c;
        int len, off;
        rst = 1'b1;
        bus.tok_valid = 1'b0;
        bus.tok_end   = 1'b0;
        bus.tok_type  = 1'b0;
        bus.tok_lit   = 8'd0;
        bus.tok_off   = 11'd0;
        bus.tok_len   = 11'd0;
        @(negedge clk);
        check("rst_oe", int'(bus.cnt_output_enable), 0);
        check("rst_out", int'(bus.cnt_output), 0);
        check("rst_len", int'(bus.cnt_len), 0);
        check("rst_finish", int'(bus.cnt_finish), 0);
        check("rst_ready", int'(bus.tok_ready), 1);
        do_reset();

        // Literal then end: 9 + 9 bits, padded with 15,15,15,1.
        send(0, 0, 8'h41, 0, 0, a);
        send(1, 0, 0, 0, 0, a);
        wait_finish("lit_end");

        // Directed matches and boundary offsets/lengths.
        do_reset();
        send(0, 1, 0, 5, 2, a);
        send(0, 0, 8'h99, 0, 0, b);
        check("match_len2_next_accept_gap", b - a, 2);
        send(0, 1, 0, 300, 8, a);
        send(0, 1, 0, 1, 23, a);
        send(0, 1, 0, 1, 37, a);
        send(0, 1, 0, 1, 38, a);
        send(0, 1, 0, 127, 7, a);
        send(0, 1, 0, 128, 22, a);
        send(0, 1, 0, 2047, 2047, a);
        send(1, 0, 0, 0, 0, a);
        wait_finish("directed");

        // Three literals with tok_valid held: three consecutive beats.
        do_reset();
        oe_run_max = 0;
        send(0, 0, 8'h01, 0, 0, a);
        send(0, 0, 8'h02, 0, 0, b);
        send(0, 0, 8'h03, 0, 0, c);
        check("lit_accept_gap", c - a, 2);
        repeat (4) @(negedge clk);
        check("lit_run_len", oe_run_max, 3);
        send(1, 0, 0, 0, 0, a);
        wait_finish("three_lit");

        // Reset in the middle of a length extension.
        do_reset();
        send(0, 1, 0, 1, 60, a);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_bits = 0;
        @(negedge clk);
        check("midrst_oe", int'(bus.cnt_output_enable), 0);
        check("midrst_out", int'(bus.cnt_output), 0);
        check("midrst_len", int'(bus.cnt_len), 0);
        check("midrst_finish", int'(bus.cnt_finish), 0);
        check("midrst_ready", int'(bus.tok_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        send(0, 0, 8'h5A, 0, 0, a);
        send(1, 0, 0, 0, 0, a);
        wait_finish("post_rst");

        // Randomized streams with idle gaps.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    send(0, 0, $urandom_range(0, 255), 0, 0, a);
                end else begin
                    off = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 127)
                                                      : $urandom_range(128, 2047);
                    case ($urandom_range(0, 3))
                        0:       len = $urandom_range(2, 7);
                        1:       len = $urandom_range(8, 22);
                        2:       len = $urandom_range(23, 60);
                        default: len = $urandom_range(61, 400);
                    endcase
                    send(0, 1, 0, off, len, a);
                end
            end
            send(1, 0, 0, 0, 0, a);
            wait_finish("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
